// File: rtl/mod_99_8_verify_respond.sv
// MAC Merge verify/respond engine: runs the verify handshake with retry limit and answers verify mPackets.
// Define MMS_RESPOND_EN to compile in the respond machine; otherwise send_r is tied low.
module mod_99_8_verify_respond #(
    parameter int VERIFY_TIME_W = 7,
    parameter int VERIFY_LIMIT  = 3,
    parameter int VERIFY_CNT_W  = 2
) (
    input  logic                     clk,
    input  logic                     reset_begin,
    input  logic                     p_enable,
    input  logic                     disable_verify,
    input  logic                     link_fail,
    input  logic [VERIFY_TIME_W-1:0] verify_time,
    input  logic                     ms_tick,
    input  logic                     rcv_r,
    input  logic                     send_v_ack,
    input  logic                     rcv_v,
    input  logic                     send_r_ack,
    output logic                     send_v,
    output logic                     send_r,
    output logic                     verified,
    output logic                     verify_fail,
    output logic [2:0]               verify_state,
    output logic [VERIFY_CNT_W-1:0]  verify_cnt
);

    typedef enum logic [2:0] {
        INIT_VERIFICATION = 3'd0,
        VERIFICATION_IDLE = 3'd1,
        SEND_VERIFY       = 3'd2,
        WAIT_FOR_RESPONSE = 3'd3,
        VERIFIED          = 3'd4,
        VERIFY_FAIL       = 3'd5
    } verify_state_t;

    localparam logic [VERIFY_CNT_W-1:0] CNT_LIMIT = VERIFY_CNT_W'(VERIFY_LIMIT);

    verify_state_t              state;
    logic [VERIFY_TIME_W-1:0]   timer;
    logic [VERIFY_TIME_W-1:0]   reload_val;
    logic                       restart;

    // A zero verify_time would make the timer expire before any tick; treat it as one tick.
    assign reload_val   = (verify_time == '0) ? VERIFY_TIME_W'(1) : verify_time;
    assign restart      = link_fail | ~p_enable | disable_verify;
    assign verify_state = state;

    // NOTE: every register here is assigned with <= so all next-state values are computed from the
    // pre-edge state; blocking assignments would let later branches see half-updated values.
    always_ff @(posedge clk) begin
        if (reset_begin) begin
            state       <= INIT_VERIFICATION;
            timer       <= '0;
            verify_cnt  <= '0;
            send_v      <= 1'b0;
            verified    <= 1'b0;
            verify_fail <= 1'b0;
        end else if (restart) begin
            state       <= INIT_VERIFICATION;
            timer       <= '0;
            verify_cnt  <= '0;
            send_v      <= 1'b0;
            // With verification disabled the link is trusted as soon as preemption is on.
            verified    <= p_enable & disable_verify;
            verify_fail <= 1'b0;
        end else begin
            unique case (state)
                INIT_VERIFICATION: begin
                    verify_cnt  <= '0;
                    verified    <= 1'b0;
                    verify_fail <= 1'b0;
                    send_v      <= 1'b0;
                    timer       <= reload_val;
                    state       <= VERIFICATION_IDLE;
                end
                VERIFICATION_IDLE: begin
                    if (timer == '0) begin
                        send_v <= 1'b1;
                        state  <= SEND_VERIFY;
                    end else if (ms_tick) begin
                        timer <= timer - VERIFY_TIME_W'(1);
                    end
                end
                SEND_VERIFY: begin
                    if (send_v_ack && send_v) begin
                        send_v <= 1'b0;
                        if (verify_cnt != CNT_LIMIT) begin
                            verify_cnt <= verify_cnt + VERIFY_CNT_W'(1);
                        end
                        timer <= reload_val;
                        state <= WAIT_FOR_RESPONSE;
                    end
                end
                WAIT_FOR_RESPONSE: begin
                    // A respond arriving on the expiry cycle still counts.
                    if (rcv_r) begin
                        verified <= 1'b1;
                        state    <= VERIFIED;
                    end else if (timer == '0) begin
                        if (verify_cnt < CNT_LIMIT) begin
                            send_v <= 1'b1;
                            state  <= SEND_VERIFY;
                        end else begin
                            verify_fail <= 1'b1;
                            state       <= VERIFY_FAIL;
                        end
                    end else if (ms_tick) begin
                        timer <= timer - VERIFY_TIME_W'(1);
                    end
                end
                VERIFIED, VERIFY_FAIL: begin
                    state <= state;
                end
                default: begin
                    state <= INIT_VERIFICATION;
                end
            endcase
        end
    end

`ifdef MMS_RESPOND_EN
    logic resp_pending;

    // Respond path ignores p_enable and the verify state: a station must always answer.
    always_ff @(posedge clk) begin
        if (reset_begin) begin
            send_r       <= 1'b0;
            resp_pending <= 1'b0;
        end else if (!send_r) begin
            send_r       <= rcv_v;
            resp_pending <= 1'b0;
        end else if (send_r_ack) begin
            send_r       <= resp_pending | rcv_v;
            resp_pending <= resp_pending & rcv_v;
        end else begin
            resp_pending <= resp_pending | rcv_v;
        end
    end
`else
    logic unused_respond_inputs;

    assign send_r                = 1'b0;
    assign unused_respond_inputs = rcv_v ^ send_r_ack;
`endif

endmodule

// File: tb/tb_mod_99_8_verify_respond.sv
// Self-checking bench for mod_99_8_verify_respond: directed scenarios plus randomized traffic
// compared each cycle against a behavioural model of the verify and respond rules.
module tb_mod_99_8_verify_respond;

    localparam int VT_W  = 7;
    localparam int LIMIT = 3;
    localparam int CNT_W = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_begin, p_enable, disable_verify, link_fail, ms_tick;
    logic              rcv_r, send_v_ack, rcv_v, send_r_ack;
    logic [VT_W-1:0]   verify_time;
    logic              send_v, send_r, verified, verify_fail;
    logic [2:0]        verify_state;
    logic [CNT_W-1:0]  verify_cnt;

    mod_99_8_verify_respond #(
        .VERIFY_TIME_W(VT_W),
        .VERIFY_LIMIT (LIMIT),
        .VERIFY_CNT_W (CNT_W)
    ) dut (
        .clk           (clk),
        .reset_begin   (reset_begin),
        .p_enable      (p_enable),
        .disable_verify(disable_verify),
        .link_fail     (link_fail),
        .verify_time   (verify_time),
        .ms_tick       (ms_tick),
        .rcv_r         (rcv_r),
        .send_v_ack    (send_v_ack),
        .rcv_v         (rcv_v),
        .send_r_ack    (send_r_ack),
        .send_v        (send_v),
        .send_r        (send_r),
        .verified      (verified),
        .verify_fail   (verify_fail),
        .verify_state  (verify_state),
        .verify_cnt    (verify_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: phase numbers follow the published verify_state values,
    // m_resp counts outstanding respond requests (one in service plus at most one queued).
    int m_phase, m_timer, m_cnt, m_resp;
    bit m_sv, m_ver, m_fail;

    task automatic model_step();
        int load;
        load = (verify_time == 0) ? 1 : int'(verify_time);
        if (reset_begin) begin
            m_phase = 0; m_timer = 0; m_cnt = 0; m_resp = 0;
            m_sv = 0; m_ver = 0; m_fail = 0;
            return;
        end
        if (link_fail || !p_enable || disable_verify) begin
            m_phase = 0; m_timer = 0; m_cnt = 0; m_sv = 0; m_fail = 0;
            m_ver = p_enable && disable_verify;
        end else begin
            case (m_phase)
                0: begin m_phase = 1; m_timer = load; m_cnt = 0; m_sv = 0; m_ver = 0; m_fail = 0; end
                1: if (m_timer == 0) begin m_phase = 2; m_sv = 1; end
                   else if (ms_tick) m_timer = m_timer - 1;
                2: if (send_v_ack) begin
                       m_sv = 0; m_timer = load; m_phase = 3;
                       m_cnt = (m_cnt + 1 > LIMIT) ? LIMIT : m_cnt + 1;
                   end
                3: if (rcv_r) begin m_phase = 4; m_ver = 1; end
                   else if (m_timer == 0) begin
                       if (m_cnt < LIMIT) begin m_phase = 2; m_sv = 1; end
                       else begin m_phase = 5; m_fail = 1; end
                   end else if (ms_tick) m_timer = m_timer - 1;
                default: ;
            endcase
        end
`ifdef MMS_RESPOND_EN
        if (send_r_ack && m_resp > 0) m_resp = m_resp - 1;
        if (rcv_v && m_resp < 2) m_resp = m_resp + 1;
`else
        m_resp = 0;
`endif
    endtask

    task automatic tick_cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic quiet();
        ms_tick = 0; rcv_r = 0; send_v_ack = 0; rcv_v = 0; send_r_ack = 0;
    endtask

    task automatic do_reset(input int vt);
        reset_begin = 1; p_enable = 1; disable_verify = 0; link_fail = 0;
        verify_time = vt[VT_W-1:0];
        quiet();
        tick_cycle();
        tick_cycle();
        reset_begin = 0;
    endtask

    task automatic test_reset();
        do_reset(10);
        reset_begin = 1;
        tick_cycle();
        n_checks++;
        if (verify_state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", verify_state); end
        n_checks++;
        if ({send_v, send_r, verified, verify_fail} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got sv=%b sr=%b ver=%b vf=%b want all 0", send_v, send_r, verified, verify_fail);
        end
        n_checks++;
        if (verify_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", verify_cnt); end
        reset_begin = 0;
    endtask

    task automatic test_verify_success();
        int ticks;
        do_reset(10);
        ticks = 0;
        ms_tick = 1;
        for (int i = 0; i < 40; i++) begin
            tick_cycle();
            if (send_v) break;
            ticks++;
        end
        ms_tick = 0;
        n_checks++;
        if (send_v !== 1'b1 || ticks != 11) begin
            n_fail++; $display("FAIL first_send_v: got send_v=%b after %0d ticks want 1 after 11", send_v, ticks);
        end
        n_checks++;
        if (verify_state !== 3'd2 || verify_cnt !== 2'd0) begin
            n_fail++; $display("FAIL send_state: got state=%0d cnt=%0d want 2/0", verify_state, verify_cnt);
        end
        send_v_ack = 1;
        tick_cycle();
        send_v_ack = 0;
        n_checks++;
        if (send_v !== 1'b0 || verify_cnt !== 2'd1 || verify_state !== 3'd3) begin
            n_fail++; $display("FAIL ack_accept: got sv=%b cnt=%0d state=%0d want 0/1/3", send_v, verify_cnt, verify_state);
        end
        for (int i = 0; i < 3; i++) begin
            ms_tick = 1; tick_cycle(); ms_tick = 0; tick_cycle();
        end
        rcv_r = 1;
        tick_cycle();
        rcv_r = 0;
        n_checks++;
        if (verified !== 1'b1 || verify_state !== 3'd4 || verify_fail !== 1'b0 || verify_cnt !== 2'd1) begin
            n_fail++; $display("FAIL verified: got ver=%b state=%0d vf=%b cnt=%0d want 1/4/0/1", verified, verify_state, verify_fail, verify_cnt);
        end
        ms_tick = 1;
        for (int i = 0; i < 15; i++) tick_cycle();
        ms_tick = 0;
        n_checks++;
        if (verify_state !== 3'd4 || verified !== 1'b1 || send_v !== 1'b0) begin
            n_fail++; $display("FAIL verified_hold: got state=%0d ver=%b sv=%b want 4/1/0", verify_state, verified, send_v);
        end
    endtask

    task automatic test_link_fail();
        link_fail = 1;
        tick_cycle();
        link_fail = 0;
        n_checks++;
        if (verify_state !== 3'd0 || verified !== 1'b0 || verify_cnt !== 2'd0) begin
            n_fail++; $display("FAIL link_fail_init: got state=%0d ver=%b cnt=%0d want 0/0/0", verify_state, verified, verify_cnt);
        end
        tick_cycle();
        n_checks++;
        if (verify_state !== 3'd1) begin n_fail++; $display("FAIL link_fail_restart: got state=%0d want 1", verify_state); end
    endtask

    task automatic test_verify_fail();
        int rises, tcount, extra;
        bit prev_sv, gap_bad, done;
        do_reset(10);
        rises = 0; tcount = 0; prev_sv = 0; gap_bad = 0; done = 0;
        for (int k = 0; k < 600; k++) begin
            ms_tick    = ((k % 3) == 0) && !send_v;
            send_v_ack = send_v;
            tick_cycle();
            if (ms_tick) tcount++;
            if (send_v && !prev_sv) begin
                rises++;
                if (rises > 1 && tcount != 10) gap_bad = 1;
                tcount = 0;
            end
            prev_sv = send_v;
            if (verify_state == 3'd5) begin done = 1; break; end
        end
        quiet();
        n_checks++;
        if (!done || rises != 3) begin n_fail++; $display("FAIL fail_attempts: got %0d send_v rises (reached=%0d) want 3", rises, done); end
        n_checks++;
        if (gap_bad) begin n_fail++; $display("FAIL fail_spacing: got retry gap other than 10 ticks want 10"); end
        n_checks++;
        if (verify_fail !== 1'b1 || verify_cnt !== 2'd3 || verified !== 1'b0 || send_v !== 1'b0) begin
            n_fail++; $display("FAIL fail_flags: got vf=%b cnt=%0d ver=%b sv=%b want 1/3/0/0", verify_fail, verify_cnt, verified, send_v);
        end
        extra = 0;
        ms_tick = 1;
        for (int i = 0; i < 30; i++) begin tick_cycle(); if (send_v) extra++; end
        ms_tick = 0;
        n_checks++;
        if (extra != 0 || verify_state !== 3'd5) begin
            n_fail++; $display("FAIL fail_absorb: got %0d send_v cycles state=%0d want 0/5", extra, verify_state);
        end
    endtask

    task automatic test_simultaneous();
        int extra;
        do_reset(2);
        tick_cycle();
        rcv_r = 1;
        tick_cycle();
        rcv_r = 0;
        n_checks++;
        if (verify_state !== 3'd1 || verified !== 1'b0) begin
            n_fail++; $display("FAIL rcv_r_idle_ignored: got state=%0d ver=%b want 1/0", verify_state, verified);
        end
        ms_tick = 1;
        for (int i = 0; i < 10 && !send_v; i++) tick_cycle();
        ms_tick = 0;
        send_v_ack = 1;
        tick_cycle();
        send_v_ack = 0;
        ms_tick = 1; tick_cycle(); tick_cycle(); ms_tick = 0;
        n_checks++;
        if (verify_state !== 3'd3) begin n_fail++; $display("FAIL sim_wait: got state=%0d want 3", verify_state); end
        rcv_r = 1;
        tick_cycle();
        rcv_r = 0;
        n_checks++;
        if (verify_state !== 3'd4 || verified !== 1'b1 || send_v !== 1'b0 || verify_cnt !== 2'd1) begin
            n_fail++; $display("FAIL sim_rcv_r_wins: got state=%0d ver=%b sv=%b cnt=%0d want 4/1/0/1", verify_state, verified, send_v, verify_cnt);
        end
        extra = 0;
        ms_tick = 1;
        for (int i = 0; i < 10; i++) begin tick_cycle(); if (send_v) extra++; end
        ms_tick = 0;
        n_checks++;
        if (extra != 0) begin n_fail++; $display("FAIL sim_no_resend: got %0d send_v cycles want 0", extra); end
    endtask

    task automatic test_respond();
        p_enable = 0;
        quiet();
`ifdef MMS_RESPOND_EN
        rcv_v = 1; tick_cycle(); rcv_v = 0;
        n_checks++;
        if (send_r !== 1'b1) begin n_fail++; $display("FAIL resp_first: got send_r=%b want 1", send_r); end
        tick_cycle();
        rcv_v = 1; tick_cycle(); rcv_v = 0;
        for (int i = 0; i < 4; i++) tick_cycle();
        send_r_ack = 1; tick_cycle(); send_r_ack = 0;
        n_checks++;
        if (send_r !== 1'b1) begin n_fail++; $display("FAIL resp_pending: got send_r=%b want 1", send_r); end
        tick_cycle();
        send_r_ack = 1; tick_cycle(); send_r_ack = 0;
        n_checks++;
        if (send_r !== 1'b0) begin n_fail++; $display("FAIL resp_done: got send_r=%b want 0", send_r); end
`else
        for (int i = 0; i < 12; i++) begin
            rcv_v      = 1'($urandom_range(0, 1));
            send_r_ack = 1'($urandom_range(0, 1));
            tick_cycle();
            n_checks++;
            if (send_r !== 1'b0) begin n_fail++; $display("FAIL resp_tied_off: got send_r=%b want 0", send_r); end
        end
`endif
        quiet();
        p_enable = 1;
    endtask

    task automatic test_reset_mid();
        do_reset(0);
        ms_tick = 1;
        rcv_v = 1;
        tick_cycle();
        rcv_v = 0;
        tick_cycle();
        n_checks++;
        if (send_v !== 1'b0) begin n_fail++; $display("FAIL zero_time_early: got send_v=%b want 0", send_v); end
        tick_cycle();
        ms_tick = 0;
        n_checks++;
        if (send_v !== 1'b1 || verify_state !== 3'd2) begin
            n_fail++; $display("FAIL zero_time_as_one: got sv=%b state=%0d want 1/2", send_v, verify_state);
        end
`ifdef MMS_RESPOND_EN
        n_checks++;
        if (send_r !== 1'b1) begin n_fail++; $display("FAIL mid_send_r: got send_r=%b want 1", send_r); end
`endif
        reset_begin = 1;
        tick_cycle();
        n_checks++;
        if ({send_v, send_r, verified, verify_fail} !== 4'b0000 || verify_state !== 3'd0 || verify_cnt !== 2'd0) begin
            n_fail++; $display("FAIL mid_reset: got sv=%b sr=%b ver=%b vf=%b state=%0d cnt=%0d want all 0",
                               send_v, send_r, verified, verify_fail, verify_state, verify_cnt);
        end
        reset_begin = 0;
        send_v_ack = 1; send_r_ack = 1;
        tick_cycle();
        quiet();
        n_checks++;
        if (verify_state !== 3'd1 || verify_cnt !== 2'd0 || send_v !== 1'b0 || send_r !== 1'b0) begin
            n_fail++; $display("FAIL stale_ack: got state=%0d cnt=%0d sv=%b sr=%b want 1/0/0/0", verify_state, verify_cnt, send_v, send_r);
        end
    endtask

    task automatic test_random();
        int local_fail;
        do_reset(int'($urandom_range(0, 4)));
        local_fail = 0;
        for (int i = 0; i < 3000 && local_fail < 5; i++) begin
            reset_begin    = ($urandom_range(0, 499) == 0);
            p_enable       = ($urandom_range(0, 99) != 0);
            disable_verify = ($urandom_range(0, 149) == 0);
            link_fail      = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 199) == 0) verify_time = VT_W'($urandom_range(0, 4));
            ms_tick    = 1'($urandom_range(0, 1));
            rcv_r      = ($urandom_range(0, 24) == 0);
            send_v_ack = ($urandom_range(0, 2) == 0);
            rcv_v      = ($urandom_range(0, 3) == 0);
            send_r_ack = ($urandom_range(0, 2) == 0);
            tick_cycle();
            n_checks++;
            if (int'(verify_state) !== m_phase || int'(verify_cnt) !== m_cnt || send_v !== m_sv ||
                verified !== m_ver || verify_fail !== m_fail || send_r !== (m_resp > 0)) begin
                n_fail++; local_fail++;
                $display("FAIL random_cycle_%0d: got state=%0d cnt=%0d sv=%b ver=%b vf=%b sr=%b want state=%0d cnt=%0d sv=%0d ver=%0d vf=%0d sr=%0d",
                         i, verify_state, verify_cnt, send_v, verified, verify_fail, send_r,
                         m_phase, m_cnt, m_sv, m_ver, m_fail, (m_resp > 0));
            end
        end
        reset_begin = 0;
        quiet();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_verify_success();
        test_link_fail();
        test_verify_fail();
        test_simultaneous();
        test_respond();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
